// File: rtl/dpath_pkg.sv
// dpath_pkg: shared constants for the count-ones datapath.
//   ALU opcodes (3 bits), shifter opcodes (2 bits), register addresses (2 bits).
package dpath_pkg;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_AND  = 3'b001;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_NOT  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_SUB  = 3'b101;
   localparam logic [2:0] ALU_INC  = 3'b110;
   localparam logic [2:0] ALU_DEC  = 3'b111;

   localparam logic [1:0] SH_NONE  = 2'b00;
   localparam logic [1:0] SH_SHL   = 2'b01;
   localparam logic [1:0] SH_SHR   = 2'b10;
   localparam logic [1:0] SH_ROR   = 2'b11;

   localparam logic [1:0] R0       = 2'd0;
   localparam logic [1:0] R1       = 2'd1;
   localparam logic [1:0] R2       = 2'd2;
   localparam logic [1:0] R3       = 2'd3;

endpackage

// File: rtl/dpath_regfile.sv
// dpath_regfile: 4 x DW register file, one write port, two enable-gated
// combinational read ports, synchronous active-low reset.
//   clk, rst_n       : clock, synchronous active-low reset
//   we, wa, wd       : write enable / address / data (written at rising edge)
//   rae, raa, a_c    : A read enable / address / data (0 when disabled)
//   rbe, rba, b_c    : B read enable / address / data (0 when disabled)
module dpath_regfile #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [1:0]    wa,
   input  logic [DW-1:0] wd,
   input  logic          rae,
   input  logic [1:0]    raa,
   input  logic          rbe,
   input  logic [1:0]    rba,
   output logic [DW-1:0] a_c,
   output logic [DW-1:0] b_c
);

   localparam int unsigned NREGS = 4;

   logic [DW-1:0] regs [NREGS];

   // Storage; reset wins over a same-cycle write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   // Reads see pre-edge contents, so read-modify-write of one address works.
   assign a_c = rae ? regs[raa] : '0;
   assign b_c = rbe ? regs[rba] : '0;

endmodule

// File: rtl/dpath_rf4.sv
// dpath_rf4: count-ones engine datapath. Executes one control word per clock:
// register-file read -> ALU -> shifter -> write-data mux -> register file,
// plus a registered output port.
//   clk, rst_n            : clock, synchronous active-low reset
//   data_in               : external operand, used when IE=1
//   IE, WE, WA            : write mux select, write enable, write address
//   RAE/RAA, RBE/RBA      : A/B read enables and addresses
//   ALU, SH               : ALU and shifter opcodes (dpath_pkg)
//   OE                    : capture shifter output into data_out
//   nEqZero               : combinational, write-data mux output == 0
//   data_out, out_valid   : registered result and one-cycle-per-OE valid
// Optional macro DPATH_FLAGS_EN adds registered carry/neg outputs.
module dpath_rf4
   import dpath_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] data_in,
   input  logic          IE,
   input  logic          WE,
   input  logic [1:0]    WA,
   input  logic          RAE,
   input  logic [1:0]    RAA,
   input  logic          RBE,
   input  logic [1:0]    RBA,
   input  logic [2:0]    ALU,
   input  logic [1:0]    SH,
   input  logic          OE,
   output logic          nEqZero,
   output logic [DW-1:0] data_out,
   output logic          out_valid
`ifdef DPATH_FLAGS_EN
   ,
   output logic          carry,
   output logic          neg
`endif
);

   logic [DW-1:0] a_bus;
   logic [DW-1:0] b_bus;
   logic [DW:0]   alu_x;
   logic [DW-1:0] alu_y;
   logic [DW-1:0] sh_y;
   logic [DW-1:0] wdata;

   dpath_regfile #(.DW(DW)) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (WE),
      .wa    (WA),
      .wd    (wdata),
      .rae   (RAE),
      .raa   (RAA),
      .rbe   (RBE),
      .rba   (RBA),
      .a_c   (a_bus),
      .b_c   (b_bus)
   );

   // ALU computed one bit wider; the top bit is carry-out (add) or borrow (sub).
   always_comb begin
      alu_x = '0;
      case (ALU)
         ALU_PASS: alu_x = {1'b0, a_bus};
         ALU_AND:  alu_x = {1'b0, a_bus & b_bus};
         ALU_OR:   alu_x = {1'b0, a_bus | b_bus};
         ALU_NOT:  alu_x = {1'b0, ~a_bus};
         ALU_ADD:  alu_x = {1'b0, a_bus} + {1'b0, b_bus};
         ALU_SUB:  alu_x = {1'b0, a_bus} - {1'b0, b_bus};
         ALU_INC:  alu_x = {1'b0, a_bus} + (DW+1)'(1);
         ALU_DEC:  alu_x = {1'b0, a_bus} - (DW+1)'(1);
         default:  alu_x = '0;
      endcase
   end

   assign alu_y = alu_x[DW-1:0];

   // Shifter on the ALU result.
   always_comb begin
      sh_y = alu_y;
      case (SH)
         SH_NONE: sh_y = alu_y;
         SH_SHL:  sh_y = {alu_y[DW-2:0], 1'b0};
         SH_SHR:  sh_y = {1'b0, alu_y[DW-1:1]};
         SH_ROR:  sh_y = {alu_y[0], alu_y[DW-1:1]};
         default: sh_y = alu_y;
      endcase
   end

   assign wdata   = IE ? data_in : sh_y;
   assign nEqZero = (wdata == '0);

   // Output port always takes the shifter value, independent of IE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= OE;
         if (OE) data_out <= sh_y;
      end
   end

`ifdef DPATH_FLAGS_EN
   // Flags captured alongside data_out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         carry <= 1'b0;
         neg   <= 1'b0;
      end else if (OE) begin
         carry <= alu_x[DW];
         neg   <= sh_y[DW-1];
      end
   end
`else
   logic unused_carry;
   assign unused_carry = alu_x[DW];
`endif

endmodule

// File: tb/tb_dpath_rf4.sv
// tb_dpath_rf4: randomized + directed bench for dpath_rf4 with a scoreboard.
// The driver predicts results from an arithmetic model and queues expected
// outputs; a negedge monitor pops and compares whenever out_valid is high.
module tb_dpath_rf4;
   import dpath_pkg::*;

   localparam int unsigned DW = 8;

   typedef struct {
      logic [7:0] d;
      logic       c;
      logic       n;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          IE = 1'b0, WE = 1'b0, RAE = 1'b0, RBE = 1'b0, OE = 1'b0;
   logic [1:0]    WA = '0, RAA = '0, RBA = '0, SH = '0;
   logic [2:0]    ALU = '0;
   logic          nEqZero;
   logic [DW-1:0] data_out;
   logic          out_valid;
`ifdef DPATH_FLAGS_EN
   logic          carry, neg;
`endif

   dpath_rf4 #(.DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .IE        (IE),
      .WE        (WE),
      .WA        (WA),
      .RAE       (RAE),
      .RAA       (RAA),
      .RBE       (RBE),
      .RBA       (RBA),
      .ALU       (ALU),
      .SH        (SH),
      .OE        (OE),
      .nEqZero   (nEqZero),
      .data_out  (data_out),
      .out_valid (out_valid)
`ifdef DPATH_FLAGS_EN
      ,
      .carry     (carry),
      .neg       (neg)
`endif
   );

   always #5 clk = ~clk;

   int   total  = 0;
   int   passes = 0;
   int   rf [4] = '{0, 0, 0, 0};
   exp_t q [$];
   logic exp_ov = 1'b0;
   logic mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      else passes++;
   endtask

   // Reference ALU: plain integer arithmetic, wrap to 8 bits, carry/borrow by range.
   function automatic void m_alu(input logic [2:0] op, input int a, input int b,
                                 output int r, output logic cy);
      int t;
      case (op)
         3'd0: t = a;
         3'd1: t = a & b;
         3'd2: t = a | b;
         3'd3: t = 255 - a;
         3'd4: t = a + b;
         3'd5: t = a - b;
         3'd6: t = a + 1;
         default: t = a - 1;
      endcase
      cy = (t > 255) || (t < 0);
      r  = ((t % 256) + 256) % 256;
   endfunction

   function automatic int m_sh(input logic [1:0] op, input int x);
      case (op)
         2'd0: return x;
         2'd1: return (x * 2) % 256;
         2'd2: return x / 2;
         default: return x / 2 + (x % 2) * 128;
      endcase
   endfunction

   // One control word: drive at negedge, check nEqZero, queue expected output.
   task automatic step(input logic rst, input logic ie, input logic we, input logic [1:0] wa,
                       input logic rae, input logic [1:0] raa, input logic rbe,
                       input logic [1:0] rba, input logic [2:0] alu, input logic [1:0] sh,
                       input logic oe, input logic [7:0] din);
      int   a, b, r, s, wd;
      logic cy;
      exp_t e;
      @(negedge clk);
      rst_n = rst; IE = ie; WE = we; WA = wa; RAE = rae; RAA = raa;
      RBE = rbe; RBA = rba; ALU = alu; SH = sh; OE = oe; data_in = din;
      a  = rae ? rf[raa] : 0;
      b  = rbe ? rf[rba] : 0;
      m_alu(alu, a, b, r, cy);
      s  = m_sh(sh, r);
      wd = ie ? int'(din) : s;
      #1;
      if (mon_en) chk("nEqZero", 32'(nEqZero), 32'(wd == 0));
      if (rst && oe) begin
         e.d = 8'(s); e.c = cy; e.n = (s >= 128);
         q.push_back(e);
      end
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 4; i++) rf[i] = 0;
      end else if (we) begin
         rf[wa] = wd;
      end
      exp_ov = rst && oe;
      mon_en = 1'b1;
   endtask

   task automatic wr_in(input logic [1:0] wa, input logic [7:0] v);
      step(1'b1, 1'b1, 1'b1, wa, 1'b0, R0, 1'b0, R0, ALU_PASS, SH_NONE, 1'b0, v);
   endtask

   task automatic op(input logic [1:0] raa, input logic [1:0] rba, input logic [2:0] alu,
                     input logic [1:0] sh, input logic we, input logic [1:0] wa, input logic oe);
      step(1'b1, 1'b0, we, wa, 1'b1, raa, 1'b1, rba, alu, sh, oe, 8'h00);
   endtask

   // Monitor: out_valid must match the previous cycle's OE; pop on every pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("data_out", 32'(data_out), 32'(e.d));
`ifdef DPATH_FLAGS_EN
               chk("carry", 32'(carry), 32'(e.c));
               chk("neg", 32'(neg), 32'(e.n));
`endif
            end
         end
      end
   end

   initial begin
      // Reset, then read every register: all zero.
      step(1'b0, 1'b0, 1'b1, R2, 1'b0, R0, 1'b0, R0, ALU_INC, SH_NONE, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b0, R0, 1'b0, R0, 1'b0, R0, ALU_PASS, SH_NONE, 1'b0, 8'h00);
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      for (int i = 0; i < 4; i++) op(2'(i), R0, ALU_PASS, SH_NONE, 1'b0, R0, 1'b0);

      // Count ones of 0xB5: R0=count, R3=1, R1=value, R2=scratch bit.
      step(1'b1, 1'b0, 1'b1, R0, 1'b0, R0, 1'b0, R0, ALU_PASS, SH_NONE, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b1, R3, 1'b0, R0, 1'b0, R0, ALU_INC, SH_NONE, 1'b0, 8'h00);
      wr_in(R1, 8'hB5);
      for (int i = 0; i < 8; i++) begin
         op(R1, R3, ALU_AND, SH_NONE, 1'b1, R2, 1'b0);
         op(R0, R2, ALU_ADD, SH_NONE, 1'b1, R0, 1'b0);
         op(R1, R0, ALU_PASS, SH_SHR, 1'b1, R1, 1'b0);
      end
      op(R0, R0, ALU_PASS, SH_NONE, 1'b0, R0, 1'b1);
      op(R0, R0, ALU_PASS, SH_NONE, 1'b0, R0, 1'b0);
      chk("popcount_b5", 32'(data_out), 32'h05);

      // Zero input write; then read R1 back through the output port.
      wr_in(R1, 8'h00);
      op(R1, R0, ALU_PASS, SH_NONE, 1'b0, R0, 1'b1);

      // ALU sweep on R2=0x81, R3=0x0F, then shifts of 0x81.
      wr_in(R2, 8'h81);
      wr_in(R3, 8'h0F);
      for (int k = 0; k < 8; k++) op(R2, R3, 3'(k), SH_NONE, 1'b0, R0, 1'b1);
      for (int k = 1; k < 4; k++) op(R2, R3, ALU_PASS, 2'(k), 1'b0, R0, 1'b1);

      // Back-to-back read-modify-write R1 <- R1>>1.
      wr_in(R1, 8'h06);
      for (int k = 0; k < 3; k++) op(R1, R0, ALU_PASS, SH_SHR, 1'b1, R1, 1'b1);
      // Reset on the second RMW cycle overrides the write.
      wr_in(R1, 8'h06);
      op(R1, R0, ALU_PASS, SH_SHR, 1'b1, R1, 1'b0);
      step(1'b0, 1'b0, 1'b1, R1, 1'b1, R1, 1'b0, R0, ALU_PASS, SH_SHR, 1'b1, 8'h00);
      op(R1, R0, ALU_PASS, SH_NONE, 1'b0, R0, 1'b1);

      // Same-cycle WE+OE with IE=1: write takes data_in, output takes shifter.
      wr_in(R2, 8'h3C);
      step(1'b1, 1'b1, 1'b1, R3, 1'b1, R2, 1'b0, R0, ALU_PASS, SH_SHL, 1'b1, 8'hA5);
      op(R3, R0, ALU_PASS, SH_NONE, 1'b0, R0, 1'b1);

      // Carry case: 0xFF + 0x01.
      wr_in(R2, 8'hFF);
      wr_in(R3, 8'h01);
      op(R2, R3, ALU_ADD, SH_NONE, 1'b0, R0, 1'b1);

      // Random control words.
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
              1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 3) != 0),
              2'($urandom), 3'($urandom), 2'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      end

      for (int n = 0; n < 3; n++) op(R0, R0, ALU_PASS, SH_NONE, 1'b0, R0, 1'b0);
      chk("queue_drained", 32'(q.size()), 32'h0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
